mem_port_ctrl: RTL and testbench

Initiator side of the single-ported unified instruction/data memory. It arbitrates between the fetch stage and the load/store stage and drives the memory port: read-enable, write-enable, 8-bit address, write data, func3. It captures the returned read data and acknowledges each requester with a registered one-cycle pulse. It also rejects misaligned or illegal-size accesses before they reach memory.

---
 rtl/mem_port_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_port_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: fetch / load-store arbiter for the single-ported memory.
// Ports: if_* fetch side, ls_* load/store side, mem_* memory port.
module mem_port_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_instr,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_func3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_IF,
    SERVE_LS
  } state_t;

  state_t state, state_nx;
  logic   last_ls;
  logic   if_elig, ls_elig;
  logic   func_ok, align_ok, ls_legal;

  // A requester in service or in its ack cycle
  // still has req high; it must not be re-served.
  assign if_elig = if_req && (state != SERVE_IF)
                   && !if_ack;
  assign ls_elig = ls_req && (state != SERVE_LS)
                   && !ls_ack;

  always_comb begin
    func_ok = 1'b0;
    case (ls_func3)
      3'b000, 3'b001, 3'b010: func_ok = 1'b1;
      3'b100, 3'b101:         func_ok = !ls_we;
      default:                func_ok = 1'b0;
    endcase
  end

  always_comb begin
    align_ok = 1'b1;
    case (ls_func3[1:0])
      2'b10:   align_ok = (ls_addr[1:0] == 2'b00);
      2'b01:   align_ok = !ls_addr[0];
      default: align_ok = 1'b1;
    endcase
  end

  assign ls_legal = func_ok && align_ok;

  always_comb begin
    state_nx = IDLE;
    unique case (1'b1)
      (if_elig && ls_elig):
        state_nx = last_ls ? SERVE_IF : SERVE_LS;
      (if_elig && !ls_elig):
        state_nx = SERVE_IF;
      (!if_elig && ls_elig):
        state_nx = SERVE_LS;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = 3'b000;
    case (state)
      SERVE_IF: begin
        mem_addr  = if_addr;
        mem_func3 = 3'b010;
      end
      SERVE_LS: begin
        mem_addr  = ls_addr;
        mem_func3 = ls_func3;
        if (ls_legal) begin
          mem_read  = !ls_we;
          mem_write = ls_we;
          if (ls_we) mem_wdata = ls_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last_ls <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx == SERVE_LS) last_ls <= 1'b1;
      if (state_nx == SERVE_IF) last_ls <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_ack   <= 1'b0;
      if_instr <= '0;
      ls_ack   <= 1'b0;
      ls_err   <= 1'b0;
      ls_rdata <= '0;
    end else begin
      if_ack <= (state == SERVE_IF);
      ls_ack <= (state == SERVE_LS);
      ls_err <= (state == SERVE_LS) && !ls_legal;
      if (state == SERVE_IF) if_instr <= mem_rdata;
      if (state == SERVE_LS) begin
        if (!ls_legal)   ls_rdata <= '0;
        else if (!ls_we) ls_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: vector table plus scoreboard bench
// for mem_port_ctrl with a byte-addressed memory model.
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_instr;
  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_func3;
  logic [7:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_port_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_instr(if_instr),
    .ls_req(ls_req), .ls_we(ls_we),
    .ls_func3(ls_func3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(ls_ack),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  logic [7:0] mem [256];

  function automatic logic [31:0] rd(
    input logic [7:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)],
         mem[8'(a + 8'd1)], mem[a]};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb mem_rdata = rd(mem_addr, mem_func3);

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] = mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00)
        mem[8'(mem_addr + 8'd1)] = mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        mem[8'(mem_addr + 8'd2)] = mem_wdata[23:16];
        mem[8'(mem_addr + 8'd3)] = mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        ls_q[$];
  logic [31:0] if_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] w;
    if (ls_ack) begin
      checks++;
      if (ls_q.size() == 0) begin
        errors++;
        $display("FAIL ls_ack unexpected at cyc %0d", cyc);
      end else begin
        e = ls_q.pop_front();
        if (ls_rdata !== e.data || ls_err !== e.err) begin
          errors++;
          $display("FAIL ls_result got %h/%b want %h/%b",
                   ls_rdata, ls_err, e.data, e.err);
        end
      end
    end
    if (if_ack) begin
      checks++;
      if (if_q.size() == 0) begin
        errors++;
        $display("FAIL if_ack unexpected at cyc %0d", cyc);
      end else begin
        w = if_q.pop_front();
        if (if_instr !== w) begin
          errors++;
          $display("FAIL if_instr got %h want %h",
                   if_instr, w);
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge with
  // the controller idle for this requester.
  task automatic ls_op(input logic we,
                       input logic [2:0] f3,
                       input logic [7:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] xd,
                       input logic xe);
    ls_we    = we;
    ls_func3 = f3;
    ls_addr  = a;
    ls_wdata = wd;
    ls_req   = 1'b1;
    ls_q.push_back('{xd, xe});
    @(negedge clk);
    chk("ls_mem_read", 32'(mem_read),
        32'(!we && !xe));
    chk("ls_mem_write", 32'(mem_write),
        32'(we && !xe));
    chk("ls_mem_addr", 32'(mem_addr), 32'(a));
    chk("ls_mem_wdata", mem_wdata,
        (we && !xe) ? wd : 32'h0);
    @(negedge clk);
    chk("ls_ack_latency", 32'(ls_ack), 32'd1);
    ls_req = 1'b0;
    @(negedge clk);
  endtask

  int ack_t;

  task automatic if_op(input logic [7:0] a,
                       input logic [31:0] xd);
    if_addr = a;
    if_req  = 1'b1;
    if_q.push_back(xd);
    @(negedge clk);
    chk("if_mem_rw", {mem_read, mem_write}, 32'd0);
    chk("if_mem_addr", 32'(mem_addr), 32'(a));
    chk("if_mem_func3", 32'(mem_func3), 32'd2);
    @(negedge clk);
    chk("if_ack_latency", 32'(if_ack), 32'd1);
    ack_t  = cyc;
    if_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          prev_t;
    int          acks;
    logic [31:0] rs_pat[9];
    logic [31:0] ra_pat[9];

    vecs[0]  = '{0, 3'b010, 8'h10, 32'h0, 32'h0000_0011, 0};
    vecs[1]  = '{1, 3'b010, 8'h0C, 32'hDEAD_BEEF, 32'h0000_0011, 0};
    vecs[2]  = '{0, 3'b000, 8'h0F, 32'h0, 32'hFFFF_FFDE, 0};
    vecs[3]  = '{0, 3'b100, 8'h0F, 32'h0, 32'h0000_00DE, 0};
    vecs[4]  = '{1, 3'b001, 8'h20, 32'h0000_1234, 32'h0000_00DE, 0};
    vecs[5]  = '{0, 3'b001, 8'h20, 32'h0, 32'h0000_1234, 0};
    vecs[6]  = '{0, 3'b101, 8'h0E, 32'h0, 32'h0000_DEAD, 0};
    vecs[7]  = '{0, 3'b100, 8'h0C, 32'h0, 32'h0000_00EF, 0};
    vecs[8]  = '{0, 3'b010, 8'h06, 32'h0, 32'h0, 1};
    vecs[9]  = '{0, 3'b001, 8'h03, 32'h0, 32'h0, 1};
    vecs[10] = '{1, 3'b100, 8'h20, 32'hFFFF_FFFF, 32'h0, 1};
    vecs[11] = '{0, 3'b010, 8'h20, 32'h0, 32'h0000_1234, 0};
    vecs[12] = '{0, 3'b010, 8'h0C, 32'h0, 32'hDEAD_BEEF, 0};
    vecs[13] = '{1, 3'b010, 8'h22, 32'hFFFF_FFFF, 32'h0, 1};
    vecs[14] = '{0, 3'b010, 8'h20, 32'h0, 32'h0000_1234, 0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]}     = 32'h0000_0013;
    {mem[7], mem[6], mem[5], mem[4]}     = 32'h0010_0093;
    {mem[11], mem[10], mem[9], mem[8]}   = 32'h0020_8113;
    {mem[19], mem[18], mem[17], mem[16]} = 32'h0000_0011;
    {mem[51], mem[50], mem[49], mem[48]} = 32'h55AA_55AA;

    rst = 1'b0;
    if_req = 1'b0; if_addr = 8'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_func3 = 3'b0;
    ls_addr = 8'h0; ls_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_acks", {if_ack, ls_ack, ls_err}, 32'd0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_mem_rw", {mem_read, mem_write}, 32'd0);
    chk("rst_mem_bus", {mem_addr, mem_func3}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      ls_op(vecs[i].we, vecs[i].f3, vecs[i].addr,
            vecs[i].wdata, vecs[i].rdata, vecs[i].err);

    // Back-to-back fetches: acks exactly 3 cycles apart.
    if_op(8'h00, 32'h0000_0013);
    prev_t = ack_t;
    if_op(8'h04, 32'h0010_0093);
    chk("if_spacing_1", 32'(ack_t - prev_t), 32'd3);
    prev_t = ack_t;
    if_op(8'h08, 32'h0020_8113);
    chk("if_spacing_2", 32'(ack_t - prev_t), 32'd3);

    // Both held: LS wins the first tie, then strict
    // alternation with an idle slot after each IF.
    rs_pat = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0,
               32'd0, 32'd1, 32'd0, 32'd0};
    ra_pat = '{32'h10, 32'h04, 32'h00, 32'h10, 32'h04,
               32'h00, 32'h10, 32'h04, 32'h00};
    for (int i = 0; i < 3; i++) begin
      ls_q.push_back('{32'h0000_0011, 1'b0});
      if_q.push_back(32'h0010_0093);
    end
    if_addr = 8'h04; if_req = 1'b1;
    ls_we = 1'b0; ls_func3 = 3'b010;
    ls_addr = 8'h10; ls_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("arb_read_%0d", i),
          32'(mem_read), rs_pat[i]);
      chk($sformatf("arb_addr_%0d", i),
          32'(mem_addr), ra_pat[i]);
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a store service.
    ls_we = 1'b1; ls_func3 = 3'b010;
    ls_addr = 8'h30; ls_wdata = 32'hCAFE_F00D;
    ls_req = 1'b1;
    @(negedge clk);
    chk("abort_write_before", 32'(mem_write), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_write_drop", 32'(mem_write), 32'd0);
    chk("abort_addr_zero", 32'(mem_addr), 32'd0);
    ls_req = 1'b0;
    @(negedge clk);
    chk("abort_mem_kept", rd(8'h30, 3'b010),
        32'h55AA_55AA);
    chk("abort_rst_state", {if_ack, ls_ack, ls_err},
        32'd0);
    chk("abort_rst_rdata", ls_rdata, 32'h0);
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ls_ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    ls_op(1'b0, 3'b010, 8'h30, 32'h0,
          32'h55AA_55AA, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(ls_q.size() + if_q.size()),
        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
